// File: rtl/sevenseg_scan_driver.sv
// Scans four captured BCD digits onto a 4-digit common-anode seven-segment display.
// Optional macro LOW_TIME_BLINK_EN blinks the time digits while the timer reads 01..09.
module sevenseg_scan_driver #(
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 16,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] ones_time,
  input  logic [3:0] tens_time,
  input  logic [3:0] ones_score,
  input  logic [3:0] tens_score,
  input  logic       display_en,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_GUARD = CNT_W'(GUARD);

  if (REFRESH_DIV < 4 || GUARD >= REFRESH_DIV || BLINK_DIV < 1) begin : g_param_check
    $error("sevenseg_scan_driver: illegal REFRESH_DIV/GUARD/BLINK_DIV combination");
  end

  typedef enum logic [1:0] {
    SLOT_ONES_SCORE = 2'd0,
    SLOT_TENS_SCORE = 2'd1,
    SLOT_ONES_TIME  = 2'd2,
    SLOT_TENS_TIME  = 2'd3
  } slot_t;

  logic [CNT_W-1:0] cnt;
  slot_t            slot;
  logic [3:0]       sh_ones_time, sh_tens_time, sh_ones_score, sh_tens_score;
  logic [3:0]       cur_digit;
  logic             is_tens;
  logic             blink_dark;
  logic             lit;
  logic [3:0]       anode_sel;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'h40;
      4'd1:    decode = 7'h79;
      4'd2:    decode = 7'h24;
      4'd3:    decode = 7'h30;
      4'd4:    decode = 7'h19;
      4'd5:    decode = 7'h12;
      4'd6:    decode = 7'h02;
      4'd7:    decode = 7'h78;
      4'd8:    decode = 7'h00;
      4'd9:    decode = 7'h10;
      default: decode = 7'h3F;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      slot <= SLOT_ONES_SCORE;
    end else if (cnt == CNT_LAST) begin
      cnt  <= '0;
      slot <= slot_t'(slot + 2'd1);
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Digits are frozen at the start of each full scan so a scan never mixes old and new values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_ones_time  <= '0;
      sh_tens_time  <= '0;
      sh_ones_score <= '0;
      sh_tens_score <= '0;
    end else if (slot == SLOT_ONES_SCORE && cnt == '0) begin
      sh_ones_time  <= ones_time;
      sh_tens_time  <= tens_time;
      sh_ones_score <= ones_score;
      sh_tens_score <= tens_score;
    end
  end

`ifdef LOW_TIME_BLINK_EN
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_on;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
      blink_cnt <= '0;
      blink_on  <= ~blink_on;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  // A timer reading 00 is steady; only 01..09 draws attention by blinking.
  assign blink_dark = !blink_on && (sh_tens_time == 4'd0) && (sh_ones_time != 4'd0) &&
                      (slot == SLOT_ONES_TIME || slot == SLOT_TENS_TIME);
`else
  assign blink_dark = 1'b0;
`endif

  always_comb begin
    cur_digit = sh_ones_score;
    is_tens   = 1'b0;
    case (slot)
      SLOT_ONES_SCORE: cur_digit = sh_ones_score;
      SLOT_TENS_SCORE: begin cur_digit = sh_tens_score; is_tens = 1'b1; end
      SLOT_ONES_TIME:  cur_digit = sh_ones_time;
      SLOT_TENS_TIME:  begin cur_digit = sh_tens_time;  is_tens = 1'b1; end
      default:         cur_digit = sh_ones_score;
    endcase
  end

  assign anode_sel = ~(4'b0001 << slot);
  assign lit = display_en && (cnt >= CNT_GUARD) && !(is_tens && cur_digit == 4'd0) && !blink_dark;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an  <= 4'hF;
      seg <= 7'h7F;
      dp  <= 1'b1;
    end else begin
      an  <= lit ? anode_sel : 4'hF;
      seg <= lit ? decode(cur_digit) : 7'h7F;
      dp  <= !(lit && slot == SLOT_ONES_TIME);
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Self-checking bench for sevenseg_scan_driver; reference model derives slot/phase from elapsed cycles.
module tb_sevenseg_scan_driver;

  localparam int R = 8;
  localparam int G = 2;
  localparam int B = 64;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] ones_time = 4'd0, tens_time = 4'd0, ones_score = 4'd0, tens_score = 4'd0;
  logic       display_en = 1'b1;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int vectors = 0;
  int miscompares = 0;

  sevenseg_scan_driver #(.REFRESH_DIV(R), .GUARD(G), .BLINK_DIV(B)) dut (
    .clk(clk), .reset(reset),
    .ones_time(ones_time), .tens_time(tens_time),
    .ones_score(ones_score), .tens_score(tens_score),
    .display_en(display_en),
    .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  // Reference model: scan position follows from cycles elapsed since reset release.
  logic [6:0]  code_tbl [16];
  int unsigned t;
  int          m_cnt, m_slot;
  logic [3:0]  m_sh [4];
  logic [3:0]  m_digit;
  logic        m_lit;
  logic [3:0]  exp_an;
  logic [6:0]  exp_seg;
  logic        exp_dp;

  initial begin
    code_tbl[0] = 7'h40; code_tbl[1] = 7'h79; code_tbl[2] = 7'h24; code_tbl[3] = 7'h30;
    code_tbl[4] = 7'h19; code_tbl[5] = 7'h12; code_tbl[6] = 7'h02; code_tbl[7] = 7'h78;
    code_tbl[8] = 7'h00; code_tbl[9] = 7'h10;
    for (int i = 10; i < 16; i++) code_tbl[i] = 7'h3F;
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      t = 0;
      for (int i = 0; i < 4; i++) m_sh[i] = 4'd0;
      exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1;
    end else begin
      m_cnt   = t % R;
      m_slot  = (t / R) % 4;
      m_digit = m_sh[m_slot];
      m_lit   = display_en && (m_cnt >= G) && !((m_slot % 2 == 1) && m_digit == 4'd0);
`ifdef LOW_TIME_BLINK_EN
      if (m_slot >= 2 && m_sh[3] == 4'd0 && m_sh[2] != 4'd0 && ((t / B) % 2 == 1)) m_lit = 1'b0;
`endif
      exp_an  = m_lit ? ~(4'b0001 << m_slot) : 4'hF;
      exp_seg = m_lit ? code_tbl[m_digit] : 7'h7F;
      exp_dp  = !(m_lit && m_slot == 2);
      if (t % (4 * R) == 0) begin
        m_sh[0] = ones_score; m_sh[1] = tens_score; m_sh[2] = ones_time; m_sh[3] = tens_time;
      end
      t++;
    end
  end

  task automatic apply_reset();
    @(negedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    ones_score = 4'd2; tens_score = 4'd4; ones_time = 4'd5; tens_time = 4'd3;
    apply_reset();
    repeat (2 * R + 4) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    vectors++;
    if ({an, seg, dp} !== {4'hF, 7'h7F, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL reset_async got an=%h seg=%h dp=%b exp an=f seg=7f dp=1", an, seg, dp);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      vectors++;
      if (an !== ((k < 3) ? 4'hF : 4'hE)) begin
        miscompares++;
        $display("[TB] FAIL reset_first_lit k=%0d got an=%h exp an=%h", k, an, (k < 3) ? 4'hF : 4'hE);
      end
    end
  endtask

  task automatic test_digits();
    logic [3:0] t_an [4];
    logic [6:0] t_seg [4];
    logic       t_dp [4];
    int sc, sl;
    logic [3:0] e_an; logic [6:0] e_seg; logic e_dp;
    t_an[0] = 4'hE; t_an[1] = 4'hD; t_an[2] = 4'hB; t_an[3] = 4'h7;
    t_seg[0] = 7'h24; t_seg[1] = 7'h19; t_seg[2] = 7'h12; t_seg[3] = 7'h30;
    t_dp[0] = 1'b1; t_dp[1] = 1'b1; t_dp[2] = 1'b0; t_dp[3] = 1'b1;
    ones_score = 4'd2; tens_score = 4'd4; ones_time = 4'd5; tens_time = 4'd3;
    apply_reset();
    for (int k = 1; k <= 4 * R; k++) begin
      @(negedge clk);
      sc = (k - 1) % R; sl = (k - 1) / R;
      e_an = (sc >= G) ? t_an[sl] : 4'hF;
      e_seg = (sc >= G) ? t_seg[sl] : 7'h7F;
      e_dp = (sc >= G) ? t_dp[sl] : 1'b1;
      vectors++;
      if ({an, seg, dp} !== {e_an, e_seg, e_dp}) begin
        miscompares++;
        $display("[TB] FAIL digits_42_35 k=%0d got an=%h seg=%h dp=%b exp an=%h seg=%h dp=%b",
                 k, an, seg, dp, e_an, e_seg, e_dp);
      end
    end
  endtask

  task automatic test_blanking();
    ones_score = 4'd0; tens_score = 4'd0; ones_time = 4'd7; tens_time = 4'd0;
    apply_reset();
    for (int k = 1; k <= 4 * R; k++) begin
      @(negedge clk);
      vectors++;
      if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
        miscompares++;
        $display("[TB] FAIL blanking k=%0d got an=%h seg=%h dp=%b exp an=%h seg=%h dp=%b",
                 k, an, seg, dp, exp_an, exp_seg, exp_dp);
      end
      if ((k - 1) % R >= G) begin
        vectors++;
        case ((k - 1) / R)
          0: if ({an, seg} !== {4'hE, 7'h40}) begin miscompares++; $display("[TB] FAIL blank_slot0 got an=%h seg=%h exp e/40", an, seg); end
          1: if ({an, seg} !== {4'hF, 7'h7F}) begin miscompares++; $display("[TB] FAIL blank_slot1 got an=%h seg=%h exp f/7f", an, seg); end
          2: if ({an, seg, dp} !== {4'hB, 7'h78, 1'b0}) begin miscompares++; $display("[TB] FAIL blank_slot2 got an=%h seg=%h dp=%b exp b/78/0", an, seg, dp); end
          default: if ({an, seg} !== {4'hF, 7'h7F}) begin miscompares++; $display("[TB] FAIL blank_slot3 got an=%h seg=%h exp f/7f", an, seg); end
        endcase
      end
    end
  endtask

  task automatic test_invalid();
    ones_score = 4'hC; tens_score = 4'hB; ones_time = 4'hF; tens_time = 4'hA;
    apply_reset();
    for (int k = 1; k <= 4 * R; k++) begin
      @(negedge clk);
      vectors++;
      if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
        miscompares++;
        $display("[TB] FAIL invalid k=%0d got an=%h seg=%h dp=%b exp an=%h seg=%h dp=%b",
                 k, an, seg, dp, exp_an, exp_seg, exp_dp);
      end
      if ((k - 1) % R >= G) begin
        vectors++;
        if (seg !== 7'h3F) begin
          miscompares++;
          $display("[TB] FAIL invalid_dash k=%0d got seg=%h exp seg=3f", k, seg);
        end
      end
    end
  endtask

  task automatic test_midscan();
    int sc, sl;
    ones_score = 4'd2; tens_score = 4'd4; ones_time = 4'd5; tens_time = 4'd3;
    apply_reset();
    for (int k = 1; k <= 6 * R; k++) begin
      @(negedge clk);
      sc = (k - 1) % R; sl = (k - 1) / R;
      vectors++;
      if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
        miscompares++;
        $display("[TB] FAIL midscan k=%0d got an=%h seg=%h dp=%b exp an=%h seg=%h dp=%b",
                 k, an, seg, dp, exp_an, exp_seg, exp_dp);
      end
      if (sc >= G && (sl == 1 || sl == 4 || sl == 5)) begin
        vectors++;
        if (seg !== ((sl == 1) ? 7'h19 : (sl == 4) ? 7'h78 : 7'h79)) begin
          miscompares++;
          $display("[TB] FAIL midscan_seg k=%0d got seg=%h exp seg=%h", k, seg,
                   (sl == 1) ? 7'h19 : (sl == 4) ? 7'h78 : 7'h79);
        end
      end
      if (k == R + 4) begin
        ones_score = 4'd7; tens_score = 4'd1;
      end
    end
  endtask

  task automatic test_display_en();
    repeat (13) @(negedge clk);
    display_en = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      vectors++;
      if ({an, seg, dp} !== {4'hF, 7'h7F, 1'b1}) begin
        miscompares++;
        $display("[TB] FAIL display_off k=%0d got an=%h seg=%h dp=%b exp f/7f/1", k, an, seg, dp);
      end
    end
    display_en = 1'b1;
    for (int k = 0; k < 4 * R; k++) begin
      @(negedge clk);
      vectors++;
      if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
        miscompares++;
        $display("[TB] FAIL display_resume k=%0d got an=%h seg=%h dp=%b exp an=%h seg=%h dp=%b",
                 k, an, seg, dp, exp_an, exp_seg, exp_dp);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 1200; k++) begin
      @(negedge clk);
      vectors++;
      if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
        miscompares++;
        $display("[TB] FAIL random k=%0d got an=%h seg=%h dp=%b exp an=%h seg=%h dp=%b",
                 k, an, seg, dp, exp_an, exp_seg, exp_dp);
      end
      if ($urandom_range(0, 9) == 0) begin
        ones_score = 4'($urandom_range(0, 15)); tens_score = 4'($urandom_range(0, 15));
        ones_time  = 4'($urandom_range(0, 11)); tens_time  = 4'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 39) == 0) display_en = ~display_en;
      if ($urandom_range(0, 149) == 0) begin
        #1 reset = 1'b1;
        #1;
        vectors++;
        if ({an, seg, dp} !== {4'hF, 7'h7F, 1'b1}) begin
          miscompares++;
          $display("[TB] FAIL random_reset k=%0d got an=%h seg=%h dp=%b exp f/7f/1", k, an, seg, dp);
        end
        reset = 1'b0;
      end
    end
    display_en = 1'b1;
  endtask

`ifdef LOW_TIME_BLINK_EN
  task automatic test_blink();
    int lit_cnt;
    for (int pass = 0; pass < 2; pass++) begin
      ones_score = 4'd3; tens_score = 4'd2; ones_time = (pass == 0) ? 4'd7 : 4'd0; tens_time = 4'd0;
      apply_reset();
      lit_cnt = 0;
      for (int k = 1; k <= 4 * B; k++) begin
        @(negedge clk);
        if (an == 4'hB) lit_cnt++;
        vectors++;
        if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
          miscompares++;
          $display("[TB] FAIL blink pass=%0d k=%0d got an=%h seg=%h dp=%b exp an=%h seg=%h dp=%b",
                   pass, k, an, seg, dp, exp_an, exp_seg, exp_dp);
        end
      end
      vectors++;
      if (lit_cnt != ((pass == 0) ? 2 * B / (4 * R) * (R - G) : 4 * B / (4 * R) * (R - G))) begin
        miscompares++;
        $display("[TB] FAIL blink_count pass=%0d got %0d exp %0d", pass, lit_cnt,
                 (pass == 0) ? 2 * B / (4 * R) * (R - G) : 4 * B / (4 * R) * (R - G));
      end
    end
  endtask
`endif

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    test_digits();
    test_blanking();
    test_invalid();
    test_midscan();
    test_display_en();
    test_random();
`ifdef LOW_TIME_BLINK_EN
    test_blink();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
